// File: rtl/conv_layer_sequencer.sv
// Sequences a convolution engine bank through every (filter group, input channel) pass.
// Optional per-pass RUN watchdog is enabled by defining CONV_SEQ_WATCHDOG_EN.
module conv_layer_sequencer #(
  parameter int unsigned ChanBits  = 10,
  parameter int unsigned GroupBits = 8
`ifdef CONV_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WdogBits  = 24
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ChanBits-1:0]  in_channels_i,
  input  logic [GroupBits-1:0] filter_groups_i,
  output logic                 wload_req_o,
  input  logic                 wload_ack_i,
  output logic [ChanBits-1:0]  wload_chan_o,
  output logic [GroupBits-1:0] wload_group_o,
  output logic                 conv_run_o,
  output logic                 conv_accumulate_o,
  input  logic                 conv_done_i,
  output logic                 group_done_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StClear, StAdvance, StFinish} state_e;

  state_e               state_q;
  logic [ChanBits-1:0]  chan_q, chan_cnt_q;
  logic [GroupBits-1:0] group_q, group_cnt_q;
  logic                 first_run_q;
  logic                 last_chan, last_group, run_done, wdog_expire, kill;

  assign last_chan     = (chan_q == chan_cnt_q - ChanBits'(1));
  assign last_group    = (group_q == group_cnt_q - GroupBits'(1));
  // The first RUN cycle may still see the previous pass's done status.
  assign run_done      = (state_q == StRun) && !first_run_q && conv_done_i;
  assign wload_chan_o  = chan_q;
  assign wload_group_o = group_q;

`ifdef CONV_SEQ_WATCHDOG_EN
  logic [WdogBits-1:0] wdog_q;

  // Held at zero outside RUN; fires at the end of the cycle in which it would reach all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != StRun) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WdogBits'(1);
    end
  end

  assign wdog_expire = (state_q == StRun) && (wdog_q == ~WdogBits'(1));
`else
  assign wdog_expire = 1'b0;
`endif

  assign kill = ((state_q != StIdle) && abort_i) || (wdog_expire && !run_done);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      chan_q            <= '0;
      chan_cnt_q        <= '0;
      group_q           <= '0;
      group_cnt_q       <= '0;
      first_run_q       <= 1'b0;
      wload_req_o       <= 1'b0;
      conv_run_o        <= 1'b0;
      conv_accumulate_o <= 1'b0;
      group_done_o      <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      group_done_o <= 1'b0;
      done_o       <= 1'b0;
      if (kill) begin
        state_q           <= StIdle;
        wload_req_o       <= 1'b0;
        conv_run_o        <= 1'b0;
        conv_accumulate_o <= 1'b0;
        busy_o            <= 1'b0;
        error_o           <= 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              chan_cnt_q  <= in_channels_i;
              group_cnt_q <= filter_groups_i;
              chan_q      <= '0;
              group_q     <= '0;
              error_o     <= 1'b0;
              busy_o      <= 1'b1;
              if (in_channels_i == '0 || filter_groups_i == '0) begin
                state_q <= StFinish;
                done_o  <= 1'b1;
              end else begin
                state_q     <= StLoad;
                wload_req_o <= 1'b1;
              end
            end
          end
          StLoad: begin
            if (wload_ack_i) begin
              state_q           <= StRun;
              wload_req_o       <= 1'b0;
              conv_run_o        <= 1'b1;
              conv_accumulate_o <= (chan_q != '0);
              first_run_q       <= 1'b1;
            end
          end
          StRun: begin
            first_run_q <= 1'b0;
            if (run_done) begin
              state_q    <= StClear;
              conv_run_o <= 1'b0;
            end
          end
          StClear: begin
            state_q           <= StAdvance;
            conv_accumulate_o <= 1'b0;
            group_done_o      <= last_chan;
          end
          StAdvance: begin
            if (last_chan) begin
              chan_q <= '0;
              if (last_group) begin
                state_q <= StFinish;
                done_o  <= 1'b1;
              end else begin
                group_q     <= group_q + GroupBits'(1);
                state_q     <= StLoad;
                wload_req_o <= 1'b1;
              end
            end else begin
              chan_q      <= chan_q + ChanBits'(1);
              state_q     <= StLoad;
              wload_req_o <= 1'b1;
            end
          end
          StFinish: begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
